// File: rtl/mod_correct_8_parts.sv
`default_nettype none
// ============================================================================
//  Module      : mod_correct_8_parts
//  Description : Corrects a signed difference into [0, p) by conditionally
//                adding p, serially in eight chunks (one chunk per cycle).
//                Optional macro MOD_CORRECT_FAST_PASS_EN: non-negative inputs
//                bypass the chunked add and complete in one cycle.
//  Revision    : 1.0 - initial release
// ============================================================================
module mod_correct_8_parts #(
  parameter int SIZE = 896
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic [SIZE:0]   diff,
  input  logic [SIZE-1:0] p,
  output logic [SIZE-1:0] result,
  output logic            done
);

  localparam int CW = SIZE / 8;

  typedef enum logic [0:0] {
    S_IDLE = 1'b0,
    S_ADD  = 1'b1
  } state_t;

  state_t          r_state;
  state_t          w_state_nxt;
  logic [SIZE-1:0] r_diff;
  logic [SIZE-1:0] r_p;
  logic [SIZE-1:0] r_parts;
  logic [SIZE-1:0] r_result;
  logic            r_sign;
  logic            r_carry;
  logic [2:0]      r_k;
  logic            w_capture;
  logic            w_fast;
  logic            w_last;
  logic [CW-1:0]   w_addend;
  logic [CW:0]     w_sum;

  always_comb begin
    w_fast      = 1'b0;
`ifdef MOD_CORRECT_FAST_PASS_EN
    w_fast      = (r_state == S_IDLE) && start && !diff[SIZE];
`endif
    w_capture   = 1'b0;
    w_last      = 1'b0;
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE: begin
        if (start && !w_fast) begin
          w_capture   = 1'b1;
          w_state_nxt = S_ADD;
        end
      end
      S_ADD: begin
        if (r_k == 3'd7) begin
          w_last      = 1'b1;
          w_state_nxt = S_IDLE;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Operands shift right one chunk per cycle, so the active chunk is always the low one.
  always_comb begin
    w_addend = r_sign ? r_p[CW-1:0] : {CW{1'b0}};
    w_sum    = {1'b0, r_diff[CW-1:0]} + {1'b0, w_addend} + {{CW{1'b0}}, r_carry};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_diff   <= '0;
      r_p      <= '0;
      r_parts  <= '0;
      r_result <= '0;
      r_sign   <= 1'b0;
      r_carry  <= 1'b0;
      r_k      <= 3'd0;
    end else if (w_capture) begin
      r_diff  <= diff[SIZE-1:0];
      r_sign  <= diff[SIZE];
      r_p     <= p;
      r_carry <= 1'b0;
      r_k     <= 3'd0;
    end else if (w_fast) begin
      r_result <= diff[SIZE-1:0];
    end else if (r_state == S_ADD) begin
      r_diff  <= r_diff >> CW;
      r_p     <= r_p >> CW;
      r_parts <= {w_sum[CW-1:0], r_parts[SIZE-1:CW]};
      r_carry <= w_sum[CW];
      r_k     <= r_k + 3'd1;
      // The carry out of the top chunk is dropped: the sum wraps modulo 2^SIZE.
      if (w_last) begin
        r_result <= {w_sum[CW-1:0], r_parts[SIZE-1:CW]};
      end
    end
  end

  assign result = r_result;
  assign done   = (r_state == S_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_mod_correct_8_parts.sv
`default_nettype none
// ============================================================================
//  Module      : tb_mod_correct_8_parts
//  Description : Scoreboard bench for mod_correct_8_parts; a monitor pops
//                expected results on every completion.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_mod_correct_8_parts;

  localparam int SIZE = 896;

  logic            clk = 1'b0;
  logic            rst;
  logic            start;
  logic [SIZE:0]   diff;
  logic [SIZE-1:0] p;
  logic [SIZE-1:0] result;
  logic            done;

  mod_correct_8_parts #(.SIZE(SIZE)) dut (
    .clk    (clk),
    .rst    (rst),
    .start  (start),
    .diff   (diff),
    .p      (p),
    .result (result),
    .done   (done)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [SIZE-1:0] res;
    bit              fast;
  } exp_t;

  exp_t            q[$];
  exp_t            m_e;
  int              vectors = 0;
  int              errors  = 0;
  int              busy    = 0;
  bit              prev_done = 1'b1;
  bit              fast_acc  = 1'b0;
  logic [SIZE-1:0] last_res  = '0;
  logic [SIZE-1:0] p25519;

  // Reference: a negative difference gets p added once, modulo 2^SIZE.
  function automatic logic [SIZE-1:0] model(input logic [SIZE:0] d, input logic [SIZE-1:0] pm);
    logic [SIZE:0] s;
    s = d;
    if (d[SIZE]) s = d + {1'b0, pm};
    return s[SIZE-1:0];
  endfunction

  function automatic logic [SIZE:0] neg(input logic [SIZE:0] v);
    logic [SIZE:0] z;
    z = '0;
    return z - v;
  endfunction

  task automatic chk(input string nm, input logic [SIZE-1:0] act, input logic [SIZE-1:0] exp);
    vectors++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h want %h (low 256 bits, upper bits %s)", nm, act[255:0], exp[255:0],
               (act[SIZE-1:256] === exp[SIZE-1:256]) ? "equal" : "differ");
    end
  endtask

  task automatic chk_int(input string nm, input int act, input int exp);
    vectors++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d want %0d", nm, act, exp);
    end
  endtask

  always @(posedge clk) begin
    fast_acc <= 1'b0;
`ifdef MOD_CORRECT_FAST_PASS_EN
    fast_acc <= !rst && start && done && !diff[SIZE];
`endif
  end

  // Monitor: result must hold while busy; each completion pops the scoreboard.
  always @(negedge clk) begin
    if (rst) begin
      busy      = 0;
      last_res  = '0;
      prev_done = 1'b1;
    end else begin
      if (!done) begin
        busy++;
        chk("hold_while_busy", result, last_res);
      end
      if (done && !prev_done) begin
        if (q.size() == 0) begin
          chk_int("unexpected_completion", 1, 0);
        end else begin
          m_e = q.pop_front();
          chk("result", result, m_e.res);
          chk_int("latency", busy, 8);
          chk_int("path_kind", int'(m_e.fast), 0);
          last_res = m_e.res;
        end
        busy = 0;
      end else if (fast_acc) begin
        if (q.size() == 0) begin
          chk_int("unexpected_fast_completion", 1, 0);
        end else begin
          m_e = q.pop_front();
          chk("fast_result", result, m_e.res);
          chk_int("fast_path_kind", int'(m_e.fast), 1);
          last_res = m_e.res;
        end
      end
      prev_done = done;
    end
  end

  task automatic push_exp(input logic [SIZE:0] d);
    exp_t e;
    e.res  = model(d, p);
    e.fast = 1'b0;
`ifdef MOD_CORRECT_FAST_PASS_EN
    e.fast = !d[SIZE];
`endif
    q.push_back(e);
  endtask

  // Issue one request; returns once the bench may present the next one.
  task automatic issue(input logic [SIZE:0] d, input bit keep_start);
    bit f;
    f = 1'b0;
`ifdef MOD_CORRECT_FAST_PASS_EN
    f = !d[SIZE];
`endif
    start = 1'b1;
    diff  = d;
    @(posedge clk); #1;
    push_exp(d);
    if (!keep_start) start = 1'b0;
    if (!f) repeat (8) @(posedge clk);
    #1;
  endtask

  initial begin
    logic [SIZE-1:0] r;
    logic [SIZE:0]   d;
    bit              ff;

    rst   = 1'b1;
    start = 1'b0;
    diff  = '0;
    p     = '0;
    p25519 = '0;
    p25519[255] = 1'b1;
    p25519 = p25519 - 19;

    #12;
    chk("reset_result", result, '0);
    chk_int("reset_done", int'(done), 1);
    @(posedge clk); #2;
    rst = 1'b0;
    p   = p25519;
    @(posedge clk); #1;

    issue({{(SIZE-2){1'b0}}, 3'd7}, 1'b0);
    issue(neg(5), 1'b0);
    issue(neg(1), 1'b0);

    // Second start during ADD must be ignored.
    ff    = 1'b0;
`ifdef MOD_CORRECT_FAST_PASS_EN
    ff    = 1'b0;
`endif
    start = 1'b1;
    diff  = neg(2);
    @(posedge clk); #1;
    push_exp(neg(2));
    start = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    start = 1'b1;
    diff  = neg(7);
    @(posedge clk); #1;
    start = 1'b0;
    repeat (5) @(posedge clk);
    repeat (12) @(posedge clk);
    #1;

    // Reset in the middle of an operation.
    start = 1'b1;
    diff  = neg(2);
    @(posedge clk); #1;
    start = 1'b0;
    repeat (3) @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    chk("midop_reset_result", result, '0);
    chk_int("midop_reset_done", int'(done), 1);
    @(posedge clk); #2;
    rst = 1'b0;
    @(posedge clk); #1;
    issue(neg(5), 1'b0);

    // Start held high, alternating signs.
    for (int i = 0; i < 6; i++) begin
      issue((i % 2 == 0) ? {{(SIZE-1){1'b0}}, 2'd3} : neg(3), 1'b1);
    end
    start = 1'b0;
    @(posedge clk); #1;

    // Randomised in-range requests with random moduli.
    for (int n = 0; n < 24; n++) begin
      for (int w = 0; w < SIZE / 32; w++) r[w*32 +: 32] = $urandom;
      r = r >> $urandom_range(0, SIZE - 8);
      if (r == '0) r = 1;
      p = r;
      for (int w = 0; w < SIZE / 32; w++) r[w*32 +: 32] = $urandom;
      r = r % p;
      if ($urandom_range(0, 1) == 1) d = neg({1'b0, r} + 1);
      else                           d = {1'b0, r};
      issue(d, 1'b0);
      repeat ($urandom_range(0, 2)) @(posedge clk);
      #1;
    end

    for (int t = 0; t < 40 && q.size() != 0; t++) @(posedge clk);
    repeat (2) @(posedge clk);
    chk_int("scoreboard_drained", q.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
`default_nettype wire
